// File: rtl/bus_rr_if.sv
// bus_rr_if: host, device and address-map signals of the round-robin system bus.
// The slave modport is the bus fabric's view; the master modport is the attached hosts/devices.
interface bus_rr_if #(
   parameter int NrHosts      = 2,
   parameter int NrDevices    = 6,
   parameter int DataWidth    = 32,
   parameter int AddressWidth = 32
);
   localparam int BeW = DataWidth / 8;
   logic [NrHosts-1:0]                   host_req_i, host_gnt_o, host_we_i;
   logic [NrHosts-1:0][AddressWidth-1:0] host_addr_i;
   logic [NrHosts-1:0][BeW-1:0]          host_be_i;
   logic [NrHosts-1:0][DataWidth-1:0]    host_wdata_i, host_rdata_o;
   logic [NrHosts-1:0]                   host_rvalid_o, host_err_o;
   logic [NrDevices-1:0]                 device_req_o, device_we_o;
   logic [NrDevices-1:0][AddressWidth-1:0] device_addr_o;
   logic [NrDevices-1:0][BeW-1:0]        device_be_o;
   logic [NrDevices-1:0][DataWidth-1:0]  device_wdata_o, device_rdata_i;
   logic [NrDevices-1:0]                 device_rvalid_i, device_err_i;
   logic [NrDevices-1:0][AddressWidth-1:0] cfg_device_addr_base_i, cfg_device_addr_mask_i;
   modport slave (
      input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
      input  device_rvalid_i, device_rdata_i, device_err_i,
      input  cfg_device_addr_base_i, cfg_device_addr_mask_i,
      output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
      output device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o
   );
   modport master (
      output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
      output device_rvalid_i, device_rdata_i, device_err_i,
      output cfg_device_addr_base_i, cfg_device_addr_mask_i,
      input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
      input  device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o
   );
endinterface

// File: rtl/bus_rr.sv
// bus_rr: round-robin multi-host system bus with address decode and in-order response tracking.
module bus_rr #(
   parameter int NrHosts        = 2,
   parameter int NrDevices      = 6,
   parameter int DataWidth      = 32,
   parameter int AddressWidth   = 32,
   parameter int MaxOutstanding = 2
) (
   input logic clk_sys_i,
   input logic rst_sys_ni,
   bus_rr_if.slave bus
);
   localparam int HostW = NrHosts > 1 ? $clog2(NrHosts) : 1;
   localparam int DevW  = NrDevices > 1 ? $clog2(NrDevices) : 1;
   localparam int PtrW  = MaxOutstanding > 1 ? $clog2(MaxOutstanding) : 1;
   localparam int CntW  = $clog2(MaxOutstanding + 1);
   logic [HostW-1:0] rr_ptr, gnt_idx, cand, head_host;
   logic [DevW-1:0] dev_idx, head_dev;
   logic [PtrW-1:0] wr_ptr, rd_ptr;
   logic [CntW-1:0] count;
   logic gnt_any, gnt_ok, dev_hit, full, pop, head_miss;
   logic [NrDevices-1:0] head_mask;
   logic [HostW-1:0] fifo_host [MaxOutstanding];
   logic [DevW-1:0] fifo_dev [MaxOutstanding];
   logic [MaxOutstanding-1:0] fifo_miss;
   assign full      = count == CntW'(MaxOutstanding);
   assign gnt_ok    = gnt_any && !full && rst_sys_ni;
   assign head_host = fifo_host[rd_ptr];
   assign head_dev  = fifo_dev[rd_ptr];
   assign head_miss = fifo_miss[rd_ptr];
   assign pop       = count != '0 && (head_miss || bus.device_rvalid_i[head_dev]);
   assign head_mask = (count != '0 && !head_miss) ? NrDevices'(1) << head_dev : '0;
   // Scan offsets downwards so the closest requester after rr_ptr is the last one written.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int i = NrHosts - 1; i >= 0; i--) begin
         cand = HostW'((int'(rr_ptr) + i) % NrHosts);
         if (bus.host_req_i[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
   end
   always_comb begin
      dev_hit = 1'b0;
      dev_idx = '0;
      for (int d = NrDevices - 1; d >= 0; d--)
         if ((bus.host_addr_i[gnt_idx] & bus.cfg_device_addr_mask_i[d]) == bus.cfg_device_addr_base_i[d]) begin
            dev_hit = 1'b1;
            dev_idx = DevW'(d);
         end
   end
   always_comb begin
      for (int h = 0; h < NrHosts; h++) begin
         bus.host_gnt_o[h]    = gnt_ok && gnt_idx == HostW'(h);
         bus.host_rvalid_o[h] = pop && head_host == HostW'(h);
         bus.host_err_o[h]    = pop && head_host == HostW'(h) && (head_miss || bus.device_err_i[head_dev]);
         bus.host_rdata_o[h]  = (pop && head_host == HostW'(h) && !head_miss) ? bus.device_rdata_i[head_dev] : '0;
      end
      for (int d = 0; d < NrDevices; d++) begin
         bus.device_req_o[d]   = gnt_ok && dev_hit && dev_idx == DevW'(d);
         bus.device_addr_o[d]  = gnt_ok ? bus.host_addr_i[gnt_idx] : '0;
         bus.device_we_o[d]    = gnt_ok && bus.host_we_i[gnt_idx];
         bus.device_be_o[d]    = gnt_ok ? bus.host_be_i[gnt_idx] : '0;
         bus.device_wdata_o[d] = gnt_ok ? bus.host_wdata_i[gnt_idx] : '0;
      end
   end
   always_ff @(posedge clk_sys_i or negedge rst_sys_ni)
      if (!rst_sys_ni) begin
         rr_ptr <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (gnt_ok) begin
            rr_ptr <= gnt_idx == HostW'(NrHosts - 1) ? '0 : gnt_idx + HostW'(1);
            wr_ptr <= wr_ptr == PtrW'(MaxOutstanding - 1) ? '0 : wr_ptr + PtrW'(1);
         end
         if (pop) rd_ptr <= rd_ptr == PtrW'(MaxOutstanding - 1) ? '0 : rd_ptr + PtrW'(1);
         count <= count + CntW'(gnt_ok) - CntW'(pop);
      end
   always_ff @(posedge clk_sys_i)
      if (gnt_ok) begin
         fifo_host[wr_ptr] <= gnt_idx;
         fifo_dev[wr_ptr]  <= dev_idx;
         fifo_miss[wr_ptr] <= !dev_hit;
      end
   stray_rvalid_a: assert property (@(posedge clk_sys_i) disable iff (!rst_sys_ni)
      (bus.device_rvalid_i & ~head_mask) == '0)
      else $warning("bus_rr: ignored device_rvalid_i %b, expected mask %b", bus.device_rvalid_i, head_mask);
endmodule

// File: doc/bus_rr.md
Name: bus_rr

Overview:
- Parametrised successor to the single-grant system bus.
- Connects NrHosts hosts (core data port, debug SBA, future DMA) to NrDevices memory-mapped devices.
- Round-robin host arbitration replaces fixed priority.
- Tracks up to MaxOutstanding in-order transactions, so devices may answer with variable latency.
- Returns a bus error for addresses that match no device.

Parameters:
- NrHosts, 2, number of host ports (>=1)
- NrDevices, 6, number of device ports (>=1)
- DataWidth, 32, data bus width
- AddressWidth, 32, address bus width
- MaxOutstanding, 2, response-tracking FIFO depth (>=1)

Ports:
- clk_sys_i  in  1  system clock
- rst_sys_ni  in  1  asynchronous active-low reset
- host_req_i  in  [NrHosts] x 1  host request
- host_gnt_o  out  [NrHosts] x 1  host grant (combinational)
- host_addr_i  in  [NrHosts] x AddressWidth  address
- host_we_i  in  [NrHosts] x 1  write enable
- host_be_i  in  [NrHosts] x DataWidth/8  byte enables
- host_wdata_i  in  [NrHosts] x DataWidth  write data
- host_rvalid_o  out  [NrHosts] x 1  response valid
- host_rdata_o  out  [NrHosts] x DataWidth  read data
- host_err_o  out  [NrHosts] x 1  response error
- device_req_o  out  [NrDevices] x 1  device request
- device_addr_o / device_we_o / device_be_o / device_wdata_o  out  [NrDevices] x widths as for hosts  forwarded request fields
- device_rvalid_i  in  [NrDevices] x 1  device response valid
- device_rdata_i  in  [NrDevices] x DataWidth  device read data
- device_err_i  in  [NrDevices] x 1  device error
- cfg_device_addr_base_i  in  [NrDevices] x AddressWidth  device base address
- cfg_device_addr_mask_i  in  [NrDevices] x AddressWidth  device address mask

Behaviour:
- Reset: rst_sys_ni asynchronous, active-low; clock clk_sys_i. All outputs 0 during reset. FIFO empty, RR pointer = 0.
- Decode: device d matches when (addr & mask[d]) == base[d]. On multiple matches the lowest index wins. No match is a decode miss.
- Arbitration:
  - At most one grant per cycle.
  - Search starts at the RR pointer and proceeds upward with wrap; the first requesting host wins.
  - Grant is combinational in the same cycle as host_req_i, and is allowed only when the FIFO is not full.
  - On grant, the RR pointer takes the value (granted+1) mod NrHosts. The pointer is unchanged when nothing is granted.
- Forwarding:
  - A granted, decoded request asserts device_req_o[d] for exactly that cycle, with the granted host's fields.
  - All other device_req_o are 0. Non-requested device field outputs may hold any value.
  - A decode miss asserts no device_req_o.
- Tracking FIFO:
  - Each grant pushes {host index, device index, miss flag}.
  - Count ranges 0..MaxOutstanding.
  - Full (count == MaxOutstanding) blocks all grants. A pop in the same cycle frees the slot only from the next cycle.
- Response path, FIFO head with device d:
  - When device_rvalid_i[d] is 1, forward rdata and err to the head host, assert host_rvalid_o for that cycle, and pop.
  - Response is combinational from device inputs to host outputs.
- Response path, FIFO head with a miss entry:
  - Respond with host_rvalid_o = 1, host_err_o = 1, rdata = 0, then pop.
  - A miss entry is never popped in the cycle it is pushed, so minimum latency is 1 cycle.
- Simultaneous events: push and pop in the same cycle leave count unchanged. A device response and a new grant in the same cycle are both legal.
- Protocol violations:
  - device_rvalid_i from a device that is not at the FIFO head, or any rvalid while the FIFO is empty, is ignored.
  - Flag with a simulation assertion.
- Idle outputs: host_rvalid_o, host_err_o and host_rdata_o are 0 for hosts not being responded to.
- Responses are strictly in grant order across all hosts.
- Reset mid-operation flushes the FIFO. Outstanding responses are lost; late device rvalids after reset are ignored per the rule above.

Test Plan:
- Single read, in-order: NrHosts=2. Host0 reads 0x00100004 (RAM base 0x00100000, mask 0xFFFF0000); RAM returns 0xDEADBEEF one cycle later. Required: gnt in cycle 0, device_req_o[0] in cycle 0, host_rvalid_o[0] with rdata 0xDEADBEEF in cycle 1.
- Round-robin: both hosts request continuously to one 1-cycle device. Required: grants alternate 0,1,0,1 with the pointer starting at 0; neither host waits more than 1 grant slot.
- Decode miss: host1 accesses 0x40000000. Required: gnt, no device_req_o, next cycle host_rvalid_o[1] = 1, host_err_o[1] = 1, rdata 0.
- Full stall: MaxOutstanding=2; a device answers after 5 cycles. Required: grants in cycles 0 and 1, no grant in cycles 2-4, responses in order, grant resumes the cycle after the first pop.
- Ordering across devices: host0 reads GPIO (latency 3), then host1 reads RAM (latency 1), RAM rvalid held until GPIO answers. Required: host0 responds first, host1 second; an early stray rvalid is ignored and the assertion fires.
- Reset mid-flight: assert rst_sys_ni=0 with 2 entries outstanding. Required: all outputs 0 immediately; after release, count 0, pointer 0, first request granted the same cycle.
